// File: rtl/ltc2308_pkg.sv
// Shared types and helpers for the LTC2308 round-robin sequencer.
// Holds the FSM state encoding and the 6-bit SDI config word layout.
package ltc2308_pkg;

    localparam int DATA_BITS = 12;
    localparam int CFG_BITS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_WAIT,
        ST_SHIFT,
        ST_PUBLISH
    } state_e;

    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, awake
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/ltc2308_adc_seq_spi_shifter.sv
// 12-bit SPI engine: two clk per bit, SDI out MSB first, SDO captured
// on the edge that ends each SCK high phase.
module adc_spi_shifter
    import ltc2308_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CFG_BITS-1:0]  cfg,
    input  logic                 adc_sdo,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    output logic                 done,
    output logic [DATA_BITS-1:0] data
);

    logic                 active_q, active_d;
    logic                 phase_q, phase_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign done = active_q & phase_q & (bit_q == 4'(DATA_BITS - 1));

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (abort) begin
            active_d = 1'b0;
            phase_d  = 1'b0;
            bit_d    = '0;
            tx_d     = '0;
            rx_d     = '0;
        end else if (start) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            bit_d    = '0;
            tx_d     = {cfg, {(DATA_BITS - CFG_BITS){1'b0}}};
        end else if (active_q) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                rx_d  = {rx_q[DATA_BITS-2:0], adc_sdo};
                tx_d  = {tx_q[DATA_BITS-2:0], 1'b0};
                bit_d = bit_q + 4'd1;
                if (done) begin
                    active_d = 1'b0;
                end
            end
        end
    end

    assign adc_sck = active_q & phase_q;
    assign adc_sdi = active_q & tx_q[DATA_BITS-1];
    assign data    = rx_q;

endmodule

// File: rtl/ltc2308_adc_seq.sv
// LTC2308 round-robin sequencer: CONVST, conversion wait, SPI shift,
// then publish {channel, code} on a valid/ready port.
module ltc2308_adc_seq
    import ltc2308_pkg::*;
#(
    parameter int unsigned CONV_CYCLES   = 64,
    parameter int unsigned CONVST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 enable,
    input  logic [7:0]           ch_mask,
    output logic                 adc_convst,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    input  logic                 adc_sdo,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [2:0]           sample_ch,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic                 pll_meta_q, pll_sync_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           cur_ch_q, cur_ch_d;
    logic [2:0]           nxt_ch_q, nxt_ch_d;
    logic [2:0]           nxt_pick;
    logic                 first_q, first_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           ch_q, ch_d;
    logic                 overrun_q, overrun_d;
    logic                 ov_set;
    logic                 locked, go, handshake;
    logic                 sh_start, sh_done;
    logic [DATA_BITS-1:0] sh_data;

    assign locked    = pll_sync_q;
    assign go        = locked & enable & (|ch_mask);
    assign handshake = valid_q & sample_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_CONVST;
            end
            ST_CONVST: begin
                if (cnt_q == 8'(CONVST_CYCLES - 1)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 8'(CONV_CYCLES - 1)) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sh_done) state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                state_d = go ? ST_CONVST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // lock loss abandons the frame wherever it is
        if (!locked) state_d = ST_IDLE;
    end

    always_comb begin
        adc_convst = (state_q == ST_CONVST);
        busy       = (state_q != ST_IDLE);
        sh_start   = (state_q == ST_WAIT) && (state_d == ST_SHIFT);
    end

    // next enabled channel strictly after cur_ch, wrapping; smallest step wins
    always_comb begin
        nxt_pick = cur_ch_q;
        for (int k = 7; k >= 1; k--) begin
            if (ch_mask[cur_ch_q + 3'(k)]) nxt_pick = cur_ch_q + 3'(k);
        end
    end

    always_comb begin
        cnt_d     = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
        nxt_ch_d  = sh_start ? nxt_pick : nxt_ch_q;
        cur_ch_d  = cur_ch_q;
        first_d   = first_q;
        valid_d   = valid_q & ~handshake;
        data_d    = data_q;
        ch_d      = ch_q;
        ov_set    = 1'b0;
        if (state_q == ST_IDLE || !locked) begin
            first_d = 1'b1;
        end else if (state_q == ST_PUBLISH) begin
            cur_ch_d = nxt_ch_q;
            first_d  = 1'b0;
            if (!first_q) begin
                if (!valid_q || handshake) begin
                    valid_d = 1'b1;
                    data_d  = sh_data;
                    ch_d    = cur_ch_q;
                end else begin
                    ov_set = 1'b1;
                end
            end
        end
        overrun_d = ov_set | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_meta_q <= 1'b0;
            pll_sync_q <= 1'b0;
            cnt_q      <= '0;
            cur_ch_q   <= '0;
            nxt_ch_q   <= '0;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
            overrun_q  <= 1'b0;
        end else begin
            pll_meta_q <= pll_locked;
            pll_sync_q <= pll_meta_q;
            cnt_q      <= cnt_d;
            cur_ch_q   <= cur_ch_d;
            nxt_ch_q   <= nxt_ch_d;
            first_q    <= first_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            overrun_q  <= overrun_d;
        end
    end

    adc_spi_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (sh_start),
        .abort   (~locked),
        .cfg     (cfg_word(nxt_pick)),
        .adc_sdo (adc_sdo),
        .adc_sck (adc_sck),
        .adc_sdi (adc_sdi),
        .done    (sh_done),
        .data    (sh_data)
    );

    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_ch    = ch_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ltc2308_adc_seq.sv
// Bench for ltc2308_adc_seq: LTC2308 pin model, rule-level channel
// reference and a result scoreboard drained on each handshake.
`timescale 1ns/1ps
module tb_ltc2308_adc_seq;

    localparam int CST_CYC = 2;
    localparam int FRAME   = 91;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h01;
    logic        adc_convst, adc_sck, adc_sdi;
    logic        adc_sdo = 1'b0;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic        busy;

    always #12.5 clk = ~clk;

    ltc2308_adc_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .adc_convst   (adc_convst),
        .adc_sck      (adc_sck),
        .adc_sdi      (adc_sdi),
        .adc_sdo      (adc_sdo),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy)
    );

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } samp_t;

    samp_t sb_q[$];
    samp_t mon_exp;

    int vectors = 0;
    int errors = 0;

    // reference and ADC pin model state
    bit          mv = 0, ov_exp = 0, ref_first = 1, force_a5c = 0;
    bit          pub, hs, loaded, dropped;
    int          ref_cur = 0, nxt, adc_cfg = -1, conv_ch = -1;
    int          bit_cnt = 12, sdi_n = 0;
    int          frames_done = 0, handshakes = 0;
    logic [11:0] conv_val = '0, sdi_word = '0;
    logic [5:0]  cfg_rx;
    logic        last_sdi = 1'b0, prev_sck = 1'b0, prev_convst = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int next_ch(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) begin
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        end
        return cur;
    endfunction

    function automatic logic [11:0] exp_sdi(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0, 6'b000000};
    endfunction

    always @(negedge clk) begin
        pub = 0;
        if (adc_convst && !prev_convst) begin
            conv_ch  = adc_cfg;
            conv_val = force_a5c ? 12'hA5C : 12'($urandom);
            bit_cnt  = 0;
            sdi_n    = 0;
            sdi_word = '0;
            adc_sdo  = conv_val[11];
        end
        if (adc_sck && !prev_sck) begin
            sdi_word = {sdi_word[10:0], last_sdi};
            sdi_n++;
        end
        if (!adc_sck && prev_sck && bit_cnt < 12) begin
            bit_cnt++;
            if (bit_cnt < 12) adc_sdo = conv_val[11 - bit_cnt];
            else pub = 1;
        end
        if (!adc_sck) last_sdi = adc_sdi;
        prev_sck    = adc_sck;
        prev_convst = adc_convst;

        if (!rst_n) begin
            sb_q.delete();
            mv        = 0;
            ov_exp    = 0;
            ref_cur   = 0;
            ref_first = 1;
        end else begin
            hs      = mv && sample_ready;
            loaded  = 0;
            dropped = 0;
            if (pub) begin
                frames_done++;
                nxt = next_ch(ch_mask, ref_cur);
                check("sdi_word", sdi_word, exp_sdi(nxt));
                check("sck_pulses", sdi_n, 12);
                cfg_rx  = sdi_word[11:6];
                adc_cfg = int'({cfg_rx[3], cfg_rx[2], cfg_rx[4]});
                if (ref_first) begin
                    ref_first = 0;
                end else begin
                    check("adc_conv_ch", conv_ch, ref_cur);
                    if (!mv || hs) begin
                        sb_q.push_back({3'(ref_cur), conv_val});
                        mv     = 1;
                        loaded = 1;
                    end else begin
                        ov_exp  = 1;
                        dropped = 1;
                    end
                end
                ref_cur = nxt;
            end
            if (hs && !loaded) mv = 0;
            if (overrun_clr && !dropped) ov_exp = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            handshakes++;
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_sample: ch %0d data %h, none queued",
                         sample_ch, sample_data);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sample_ch", sample_ch, mon_exp.ch);
                check("sample_data", sample_data, mon_exp.data);
            end
        end
    end

    task automatic wait_samples(input int n);
        int target;
        int t;
        target = handshakes + n;
        t = 0;
        while (handshakes < target && t < (n + 2) * FRAME * 2) begin
            @(posedge clk);
            t++;
        end
        vectors++;
        if (handshakes < target) begin
            errors++;
            $display("FAIL wait_samples: got %0d required %0d",
                     handshakes - target + n, n);
        end
    endtask

    task automatic wait_frames(input int n);
        int target;
        int t;
        target = frames_done + n;
        t = 0;
        while (frames_done < target && t < (n + 2) * FRAME * 2) begin
            @(posedge clk);
            t++;
        end
        vectors++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL wait_frames: got %0d required %0d",
                     frames_done - target + n, n);
        end
    endtask

    task automatic stop_and_restart(input logic [7:0] m);
        int t;
        @(posedge clk);
        #1 enable = 1'b0;
        t = 0;
        while (busy && t < FRAME * 3) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("stop_idle", busy, 0);
        ch_mask   = m;
        ref_first = 1;
        enable    = 1'b1;
    endtask

    initial begin
        int n;
        logic [11:0] held;

        rst_n      = 1'b0;
        enable     = 1'b1;
        ch_mask    = 8'h01;
        pll_locked = 1'b0;
        force_a5c  = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {adc_convst, adc_sck, adc_sdi,
                            sample_valid, overrun, busy}, 0);
        check("reset_data", {sample_ch, sample_data}, 0);
        rst_n = 1'b1;

        n = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (adc_convst || busy) n++;
        end
        check("unlocked_convst", n, 0);

        @(negedge clk);
        pll_locked = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("convst_early", adc_convst, 0);
        @(posedge clk);
        #1 check("convst_lock3", adc_convst, 1);

        n = 0;
        while (adc_convst && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        n = 0;
        while (!adc_convst && n < 500) begin
            @(posedge clk);
            #1 n++;
        end
        check("frame_period", n + CST_CYC, FRAME);

        wait_samples(4);
        force_a5c = 0;
        wait_samples(3);

        stop_and_restart(8'h85);
        wait_samples(7);

        for (int i = 0; i < 3; i++) begin
            stop_and_restart(8'($urandom_range(1, 255)));
            wait_samples(5);
        end

        @(posedge clk);
        #1 sample_ready = 1'b0;
        wait_frames(3);
        @(posedge clk);
        #1;
        check("bp_valid", sample_valid, 1);
        check("bp_overrun", overrun, 1);
        check("bp_queue", sb_q.size(), 1);
        held = sb_q[0].data;
        check("bp_held", sample_data, held);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        @(posedge clk);
        #1 check("ovr_clr", overrun, 0);
        check("ovr_model", overrun, ov_exp);
        sample_ready = 1'b1;
        wait_samples(3);

        n = 0;
        while (!(adc_sck === 1'b0 && sdi_n == 5 && busy) && n < FRAME * 3) begin
            @(posedge clk);
            #1 n++;
        end
        check("reach_bit5", sdi_n, 5);
        pll_locked = 1'b0;
        ref_first  = 1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_outs", {adc_sck, adc_convst, busy}, 0);
        pll_locked = 1'b1;
        wait_samples(4);

        n = 0;
        while (!adc_convst && n < FRAME * 3) begin
            @(posedge clk);
            #1 n++;
        end
        while (adc_convst && n < FRAME * 3) begin
            @(posedge clk);
            #1 n++;
        end
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wait_ctl", {adc_convst, adc_sck, adc_sdi,
                               sample_valid, overrun, busy}, 0);
        check("rst_wait_data", {sample_ch, sample_data}, 0);
        rst_n = 1'b1;
        wait_samples(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #(25.0 * 60000);
        $display("FAIL global_timeout: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

endmodule
